// File: rtl/muxpga_cfg_loader.sv
// Serial configuration loader for the mux fabric. It hunts for a sync word, then shifts
// CFG_BITS bits MSB-first into a shadow register, checks even parity, and commits the result.
module muxpga_cfg_loader #(
   parameter int                CFG_BITS  = 16,
   parameter int                SYNC_W    = 4,
   parameter logic [SYNC_W-1:0] SYNC_WORD = 4'b1010
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_mode,
   input  logic                cfg_data,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   output logic [CFG_BITS-1:0] active_cfg,
   output logic                fabric_en,
   output logic                busy,
   output logic                commit_pulse,
   output logic                error
);

   localparam int CNT_W = $clog2(CFG_BITS + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HUNT   = 3'd1,
      ST_LOAD   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_COMMIT = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

   state_t              state_r;
   logic [SYNC_W-1:0]   sync_r;
   logic [CFG_BITS-1:0] shadow_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                parity_r;
   logic                loaded_r;
   logic                cfg_mode_q_r;
   logic [SYNC_W-1:0]   sync_next_s;
   logic                bit_accept_s;

   // Even parity holds when the data accumulator and the trailer bit cancel.
   function automatic logic parity_ok(input logic acc, input logic trailer);
      return (acc ^ trailer) == 1'b0;
   endfunction

   // Decode of registered state: handshake, busy and fabric gating.
   always_comb begin
      cfg_ready    = 1'b0;
      busy         = 1'b0;
      fabric_en    = 1'b0;
      bit_accept_s = 1'b0;
      sync_next_s  = {sync_r[SYNC_W-2:0], cfg_data};
      if ((state_r == ST_HUNT) || (state_r == ST_LOAD) || (state_r == ST_CHECK)) begin
         cfg_ready = 1'b1;
      end else begin
         cfg_ready = 1'b0;
      end
      busy         = (state_r != ST_IDLE);
      fabric_en    = loaded_r & (state_r == ST_IDLE) & ~cfg_mode;
      bit_accept_s = cfg_valid & cfg_ready;
   end

   // Load sequencer plus all datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         sync_r       <= {SYNC_W{1'b0}};
         shadow_r     <= {CFG_BITS{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         parity_r     <= 1'b0;
         loaded_r     <= 1'b0;
         cfg_mode_q_r <= 1'b0;
         active_cfg   <= {CFG_BITS{1'b0}};
         commit_pulse <= 1'b0;
         error        <= 1'b0;
      end else begin
         cfg_mode_q_r <= cfg_mode;
         commit_pulse <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cfg_mode && !cfg_mode_q_r) begin
                  state_r <= ST_HUNT;
                  sync_r  <= {SYNC_W{1'b0}};
                  error   <= 1'b0;
               end
            end
            // Dropping cfg_mode wins over any bit offered in the same cycle.
            ST_HUNT: begin
               if (!cfg_mode) begin
                  state_r <= ST_IDLE;
               end else if (bit_accept_s) begin
                  sync_r <= sync_next_s;
                  if (sync_next_s == SYNC_WORD) begin
                     state_r  <= ST_LOAD;
                     cnt_r    <= {CNT_W{1'b0}};
                     parity_r <= 1'b0;
                  end
               end
            end
            ST_LOAD: begin
               if (!cfg_mode) begin
                  state_r <= ST_IDLE;
               end else if (bit_accept_s) begin
                  shadow_r <= {shadow_r[CFG_BITS-2:0], cfg_data};
                  parity_r <= parity_r ^ cfg_data;
                  cnt_r    <= cnt_r + CNT_W'(1);
                  if (cnt_r == CNT_W'(CFG_BITS - 1)) begin
                     state_r <= ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               if (!cfg_mode) begin
                  state_r <= ST_IDLE;
               end else if (bit_accept_s) begin
                  if (parity_ok(parity_r, cfg_data)) begin
                     state_r      <= ST_COMMIT;
                     commit_pulse <= 1'b1;
                  end else begin
                     state_r <= ST_ERR;
                     error   <= 1'b1;
                  end
               end
            end
            ST_COMMIT: begin
               active_cfg <= shadow_r;
               loaded_r   <= 1'b1;
               state_r    <= ST_IDLE;
            end
            ST_ERR: begin
               if (!cfg_mode) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
